// File: rtl/face_matrix_pkg.sv
// Shared types and 8x8 glyph artwork for the face matrix scanner.
// Glyph byte bit 7 is the leftmost column; row 0 is the top row.
package face_matrix_pkg;

  typedef enum logic [1:0] {
    MODE_SMILE = 2'd0,
    MODE_FROWN = 2'd1,
    MODE_WINK  = 2'd2,
    MODE_TEST  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int GLYPH_DIM = 8;

  // Row 0 sits in the most significant byte.
  localparam logic [63:0] GLYPH_SMILE    = 64'h0066_6666_0042_2418;
  localparam logic [63:0] GLYPH_FROWN    = 64'h0066_6666_0018_2442;
  localparam logic [63:0] GLYPH_WINK_ODD = 64'h0060_6660_0042_2418;
  localparam logic [63:0] GLYPH_ALL_ON   = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [7:0] glyph_row(input mode_e m, input logic odd, input logic [2:0] r);
    logic [63:0] g;
    logic [5:0]  base;
    case (m)
      MODE_SMILE: g = GLYPH_SMILE;
      MODE_FROWN: g = GLYPH_FROWN;
      MODE_WINK:  g = odd ? GLYPH_WINK_ODD : GLYPH_SMILE;
      MODE_TEST:  g = GLYPH_ALL_ON;
      default:    g = 64'h0;
    endcase
    base = 6'd63 - {r, 3'b000};
    return g[base -: 8];
  endfunction

endpackage

// File: rtl/face_glyph_rom.sv
// Combinational glyph lookup: maps a matrix row to its column bits, centring
// the 8x8 art on larger matrices and keeping its top-left corner on smaller ones.
module face_glyph_rom
  import face_matrix_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  mode_e            i_mode,
  input  logic             i_frame_odd,
  input  logic [3:0]       i_row_idx,
  output logic [COLS-1:0]  o_col
);

  localparam int ROW_OFF  = (ROWS > GLYPH_DIM) ? (ROWS - GLYPH_DIM) / 2 : 0;
  localparam int COL_OFF  = (COLS > GLYPH_DIM) ? (COLS - GLYPH_DIM) / 2 : 0;
  localparam int COL_CROP = (COLS < GLYPH_DIM) ? GLYPH_DIM - COLS : 0;

  logic [7:0] w_bits;

  // Select the glyph row, then place its bits into the matrix column space.
  always_comb begin
    int src_row;
    int src_col;
    w_bits  = 8'h00;
    o_col   = '0;
    src_row = int'(i_row_idx) - ROW_OFF;
    if (src_row >= 0 && src_row < GLYPH_DIM) begin
      w_bits = glyph_row(i_mode, i_frame_odd, 3'(src_row));
    end else begin
      w_bits = 8'h00;
    end
    for (int c = 0; c < COLS; c++) begin
      src_col = c - COL_OFF + COL_CROP;
      if (src_col >= 0 && src_col < GLYPH_DIM) begin
        o_col[c] = w_bits[3'(src_col)];
      end else begin
        o_col[c] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/face_matrix_scanner.sv
// Row-scanned LED-matrix face animator: FSM, scan-tick divider, row/frame/beep
// counters and registered matrix, buzzer and done outputs.
module face_matrix_scanner
  import face_matrix_pkg::*;
#(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int SCAN_DIV    = 1,
  parameter int BEEP_DIV    = 11,
  parameter int HOLD_FRAMES = 50
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_en,
  input  logic [1:0]      i_mode,
  output logic [ROWS-1:0] o_row_n,
  output logic [COLS-1:0] o_col,
  output logic            o_beep,
  output logic            o_done
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;
  localparam int FW = $clog2(HOLD_FRAMES + 1);

  state_e          r_state, w_state_next;
  logic [DW-1:0]   r_div;
  logic [BW-1:0]   r_beep_cnt;
  logic [FW-1:0]   r_frame_cnt, w_frame_next;
  logic [3:0]      r_row_idx, w_row_next, w_rom_row;
  mode_e           r_mode_lat, w_rom_mode;
  logic            r_frame_odd, w_rom_odd;
  logic            w_tick, w_wrap;
  logic [ROWS-1:0] r_row_n;
  logic [COLS-1:0] r_col, w_glyph;
  logic            r_beep, r_done;

  // Tick/wrap decode and the glyph address for the row about to be shown.
  always_comb begin
    w_tick       = (r_state != ST_IDLE) && (r_div == DW'(SCAN_DIV - 1));
    w_wrap       = w_tick && (r_row_idx == 4'(ROWS - 1));
    w_frame_next = r_frame_cnt;
    w_row_next   = r_row_idx;
    if (w_wrap && (r_frame_cnt != FW'(HOLD_FRAMES))) begin
      w_frame_next = r_frame_cnt + FW'(1);
    end else begin
      w_frame_next = r_frame_cnt;
    end
    if (w_tick) begin
      w_row_next = w_wrap ? 4'd0 : r_row_idx + 4'd1;
    end else begin
      w_row_next = r_row_idx;
    end
    if (r_state == ST_IDLE) begin
      w_rom_mode = mode_e'(i_mode);
      w_rom_odd  = 1'b0;
      w_rom_row  = 4'd0;
    end else begin
      w_rom_mode = w_wrap ? mode_e'(i_mode) : r_mode_lat;
      w_rom_odd  = w_wrap ? ~r_frame_odd : r_frame_odd;
      w_rom_row  = w_row_next;
    end
  end

  face_glyph_rom #(.ROWS(ROWS), .COLS(COLS)) u_rom (
    .i_mode      (w_rom_mode),
    .i_frame_odd (w_rom_odd),
    .i_row_idx   (w_rom_row),
    .o_col       (w_glyph)
  );

  // Next-state logic; dropping enable always returns to idle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: w_state_next = i_en ? ST_SCAN : ST_IDLE;
      ST_SCAN: begin
        if (!i_en) begin
          w_state_next = ST_IDLE;
        end else if (w_wrap && (w_frame_next == FW'(HOLD_FRAMES))) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_SCAN;
        end
      end
      ST_DONE: w_state_next = i_en ? ST_DONE : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Counters, mode latch and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0; r_beep_cnt <= '0; r_frame_cnt <= '0; r_row_idx <= 4'd0;
      r_mode_lat <= MODE_SMILE; r_frame_odd <= 1'b0;
      r_row_n <= '1; r_col <= '0; r_beep <= 1'b0; r_done <= 1'b0;
    end else if (!i_en) begin
      r_div <= '0; r_beep_cnt <= '0; r_frame_cnt <= '0; r_row_idx <= 4'd0;
      r_mode_lat <= MODE_SMILE; r_frame_odd <= 1'b0;
      r_row_n <= '1; r_col <= '0; r_beep <= 1'b0; r_done <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_div <= '0; r_beep_cnt <= '0; r_frame_cnt <= '0; r_row_idx <= 4'd0;
      r_mode_lat <= mode_e'(i_mode); r_frame_odd <= 1'b0;
      r_row_n <= ~{{(ROWS-1){1'b0}}, 1'b1}; r_col <= w_glyph;
      r_beep <= 1'b0; r_done <= 1'b0;
    end else begin
      r_div <= w_tick ? '0 : r_div + DW'(1);
      if (w_tick) begin
        r_row_idx <= w_row_next;
        r_row_n   <= ~({{(ROWS-1){1'b0}}, 1'b1} << w_row_next);
        r_col     <= w_glyph;
      end else begin
        r_row_idx <= r_row_idx;
      end
      if (w_wrap) begin
        r_frame_cnt <= w_frame_next;
        r_mode_lat  <= mode_e'(i_mode);
        r_frame_odd <= ~r_frame_odd;
      end else begin
        r_frame_cnt <= r_frame_cnt;
      end
      // The buzzer only sounds while still counting frames.
      if (w_state_next == ST_DONE) begin
        r_beep     <= 1'b0;
        r_beep_cnt <= '0;
      end else if (w_tick) begin
        if (r_beep_cnt == BW'(BEEP_DIV - 1)) begin
          r_beep     <= ~r_beep;
          r_beep_cnt <= '0;
        end else begin
          r_beep_cnt <= r_beep_cnt + BW'(1);
        end
      end else begin
        r_beep_cnt <= r_beep_cnt;
      end
      r_done <= (w_state_next == ST_DONE);
    end
  end

  assign o_row_n = r_row_n;
  assign o_col   = r_col;
  assign o_beep  = r_beep;
  assign o_done  = r_done;

endmodule
